// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback source select, load extension and MDU result merge into the RF write port
module wb_stage #(
   parameter int MDU_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic [1:0]  wb_sel,
   input  logic [31:0] wb_alu,
   input  logic [31:0] wb_pc4,
   input  logic [31:0] wb_imm,
   input  logic [2:0]  wb_funct3,
   input  logic [1:0]  wb_addr_lo,
   input  logic [31:0] wb_mem_rdata,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_rd,
   input  logic [31:0] mdu_data,
   output logic        mdu_ready,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        mdu_pending
);

   localparam int PW = $clog2(MDU_DEPTH);

   logic [PW:0]   r_cnt;
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [4:0]    r_q_rd   [MDU_DEPTH];
   logic [31:0]   r_q_data [MDU_DEPTH];

   logic        w_pipe_hit;
   logic        w_push;
   logic        w_pop;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_pipe_wdata;
   logic        w_nxt_we;
   logic [4:0]  w_nxt_waddr;
   logic [31:0] w_nxt_wdata;

   assign w_pipe_hit  = wb_valid && (wb_rd != 5'd0);
   assign mdu_ready   = (r_cnt != (PW+1)'(MDU_DEPTH));
   // Push is masked during reset so the hazard unit never sees a phantom pending result.
   assign w_push      = mdu_valid && mdu_ready && !rst;
   assign w_pop       = !w_pipe_hit && (r_cnt != '0);
   assign mdu_pending = (r_cnt != '0) || w_push;

   always_comb begin
      w_byte = wb_mem_rdata[7:0];
      case (wb_addr_lo)
         2'd0: w_byte = wb_mem_rdata[7:0];
         2'd1: w_byte = wb_mem_rdata[15:8];
         2'd2: w_byte = wb_mem_rdata[23:16];
         2'd3: w_byte = wb_mem_rdata[31:24];
         default: w_byte = wb_mem_rdata[7:0];
      endcase
      w_half = wb_addr_lo[1] ? wb_mem_rdata[31:16] : wb_mem_rdata[15:0];
      case (wb_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load = {24'd0, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b101:  w_load = {16'd0, w_half};
         default: w_load = wb_mem_rdata;
      endcase
   end

   always_comb begin
      w_pipe_wdata = wb_alu;
      case (wb_sel)
         2'b00:   w_pipe_wdata = wb_alu;
         2'b01:   w_pipe_wdata = w_load;
         2'b10:   w_pipe_wdata = wb_pc4;
         2'b11:   w_pipe_wdata = wb_imm;
         default: w_pipe_wdata = wb_alu;
      endcase
   end

   // An MDU result aimed at x0 still drains its slot, it just never raises the write enable.
   always_comb begin
      w_nxt_we    = 1'b0;
      w_nxt_waddr = 5'd0;
      w_nxt_wdata = 32'd0;
      if (w_pipe_hit) begin
         w_nxt_we    = 1'b1;
         w_nxt_waddr = wb_rd;
         w_nxt_wdata = w_pipe_wdata;
      end else if (w_pop) begin
         w_nxt_we    = (r_q_rd[r_rptr] != 5'd0);
         w_nxt_waddr = r_q_rd[r_rptr];
         w_nxt_wdata = r_q_data[r_rptr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= 5'd0;
         rf_wdata <= 32'd0;
      end else begin
         rf_we    <= w_nxt_we;
         rf_waddr <= w_nxt_waddr;
         rf_wdata <= w_nxt_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + PW'(1);
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_rd[r_wptr]   <= mdu_rd;
         r_q_data[r_wptr] <= mdu_data;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized scoreboard bench for wb_stage
module tb_wb_stage;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [1:0]  wb_sel = '0;
   logic [31:0] wb_alu = '0;
   logic [31:0] wb_pc4 = '0;
   logic [31:0] wb_imm = '0;
   logic [2:0]  wb_funct3 = '0;
   logic [1:0]  wb_addr_lo = '0;
   logic [31:0] wb_mem_rdata = '0;
   logic        mdu_valid = 1'b0;
   logic [4:0]  mdu_rd = '0;
   logic [31:0] mdu_data = '0;
   logic        mdu_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        mdu_pending;

   always #5 clk = ~clk;

   wb_stage #(.MDU_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_sel(wb_sel),
      .wb_alu(wb_alu), .wb_pc4(wb_pc4), .wb_imm(wb_imm),
      .wb_funct3(wb_funct3), .wb_addr_lo(wb_addr_lo), .wb_mem_rdata(wb_mem_rdata),
      .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mdu_pending(mdu_pending)
   );

   typedef struct {logic [4:0] rd; logic [31:0] data;} mdu_t;
   typedef struct {logic we; logic [4:0] addr; logic [31:0] data;} wr_t;

   mdu_t src[$];
   mdu_t mq[$];
   wr_t  exq[$];
   wr_t  m_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_wd(input logic [1:0] sel, input logic [31:0] alu,
                                          input logic [31:0] pc4, input logic [31:0] imm,
                                          input logic [2:0] f3, input logic [1:0] alo,
                                          input logic [31:0] mem);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(mem >> (8 * alo));
      h = 16'(mem >> (16 * alo[1]));
      case (sel)
         2'd0: return alu;
         2'd2: return pc4;
         2'd3: return imm;
         default:
            case (f3)
               3'd0:    return 32'($signed(b));
               3'd4:    return {24'd0, b};
               3'd1:    return 32'($signed(h));
               3'd5:    return {16'd0, h};
               default: return mem;
            endcase
      endcase
   endfunction

   task automatic add_mdu(input logic [4:0] rd, input logic [31:0] data);
      mdu_t m;
      m.rd = rd;
      m.data = data;
      src.push_back(m);
   endtask

   task automatic step(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [2:0] f3, input logic [1:0] alo,
                       input logic [31:0] mem, input bit use_lit = 1'b0,
                       input logic [31:0] lit = 32'd0);
      wr_t  e;
      mdu_t h;
      bit   hit, rdy, push, pend;
      @(negedge clk);
      wb_valid = v; wb_rd = rd; wb_sel = sel; wb_alu = alu;
      wb_funct3 = f3; wb_addr_lo = alo; wb_mem_rdata = mem;
      wb_pc4 = $urandom; wb_imm = $urandom;
      if (src.size() > 0) begin
         mdu_valid = 1'b1; mdu_rd = src[0].rd; mdu_data = src[0].data;
      end else begin
         mdu_valid = 1'b0; mdu_rd = 5'($urandom); mdu_data = $urandom;
      end
      hit  = v && (rd != 5'd0);
      rdy  = mq.size() < DEPTH;
      push = mdu_valid && rdy;
      pend = (mq.size() != 0) || push;
      #1;
      chk("mdu_ready", mdu_ready, rdy);
      chk("mdu_pending", mdu_pending, pend);
      if (hit) begin
         e.we = 1'b1; e.addr = rd;
         e.data = use_lit ? lit : ref_wd(sel, alu, wb_pc4, wb_imm, f3, alo, mem);
      end else if (mq.size() > 0) begin
         h = mq.pop_front();
         e.we = (h.rd != 5'd0); e.addr = h.rd; e.data = h.data;
      end else begin
         e.we = 1'b0; e.addr = 5'd0; e.data = 32'd0;
      end
      if (push) mq.push_back(src.pop_front());
      exq.push_back(e);
   endtask

   task automatic idle();
      step(1'b0, 5'($urandom), 2'($urandom), $urandom, 3'd0, 2'd0, $urandom);
   endtask

   task automatic busy();
      step(1'b1, 5'($urandom_range(1, 31)), 2'd0, $urandom, 3'd0, 2'd0, $urandom);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      wb_valid = 1'b1; wb_rd = 5'd9; wb_sel = 2'd0; wb_alu = $urandom;
      mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = $urandom;
      #1;
      chk("rst_rf_we", rf_we, 1'b0);
      chk("rst_rf_waddr", rf_waddr, 5'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_mdu_ready", mdu_ready, 1'b1);
      chk("rst_mdu_pending", mdu_pending, 1'b0);
      repeat (2) @(negedge clk);
      mq.delete(); src.delete(); exq.delete();
      wb_valid = 1'b0; mdu_valid = 1'b0;
      rst = 1'b0;
   endtask

   // Monitor: each registered write is compared against the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (!rst && exq.size() > 0) begin
         m_e = exq.pop_front();
         chk("rf_we", rf_we, m_e.we);
         if (m_e.we) begin
            chk("rf_waddr", rf_waddr, m_e.addr);
            chk("rf_wdata", rf_wdata, m_e.data);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();
      step(1'b1, 5'd5, 2'd0, 32'h1234, 3'd0, 2'd0, 32'd0, 1'b1, 32'h0000_1234);

      step(1'b1, 5'd10, 2'b01, $urandom, 3'b000, 2'd2, 32'h80FF7F01, 1'b1, 32'hFFFFFFFF);
      step(1'b1, 5'd11, 2'b01, $urandom, 3'b100, 2'd3, 32'h80FF7F01, 1'b1, 32'h00000080);
      step(1'b1, 5'd12, 2'b01, $urandom, 3'b001, 2'd0, 32'h80FF7F01, 1'b1, 32'h00007F01);
      step(1'b1, 5'd13, 2'b01, $urandom, 3'b101, 2'd2, 32'h80FF7F01, 1'b1, 32'h000080FF);
      step(1'b1, 5'd14, 2'b01, $urandom, 3'b001, 2'd3, 32'h80FF7F01, 1'b1, 32'hFFFF80FF);
      step(1'b1, 5'd15, 2'b01, $urandom, 3'b010, 2'd1, 32'h80FF7F01, 1'b1, 32'h80FF7F01);

      add_mdu(5'd7, 32'h0000_DEAD);
      repeat (3) idle();

      add_mdu(5'd20, 32'hA0A0_0001);
      add_mdu(5'd21, 32'hA0A0_0002);
      add_mdu(5'd22, 32'hA0A0_0003);
      repeat (4) busy();
      repeat (5) idle();

      add_mdu(5'd8, 32'h0BAD_F00D);
      idle();
      step(1'b1, 5'd0, 2'd0, $urandom, 3'd0, 2'd0, $urandom);
      idle();

      add_mdu(5'd0, 32'h1111_1111);
      repeat (3) idle();

      add_mdu(5'd24, 32'hCAFE_0001);
      add_mdu(5'd25, 32'hCAFE_0002);
      repeat (2) busy();
      do_reset();
      repeat (3) idle();

      for (int i = 0; i < 1500; i++) begin
         if (src.size() == 0 && $urandom_range(0, 2) == 0)
            add_mdu(5'($urandom_range(0, 31)), $urandom);
         if ($urandom_range(0, 299) == 0)
            do_reset();
         else
            step(1'($urandom), 5'($urandom), 2'($urandom), $urandom,
                 3'($urandom), 2'($urandom), $urandom);
      end

      for (int i = 0; i < 20 && (mq.size() != 0 || src.size() != 0); i++)
         idle();
      chk("drain_left", mq.size() + src.size(), 0);
      @(posedge clk);
      #2;
      chk("exp_left", exq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
